// File: rtl/actuator_update_sequencer_pkg.sv
// ============================================================================
// Module   : actuator_update_sequencer_pkg
// Purpose  : Shared constants and FSM state type for the actuator sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package actuator_update_sequencer_pkg;

  localparam int CELLS         = 10;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_REPW  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/actuator_update_sequencer_pattern_fifo.sv
// ============================================================================
// Module   : pattern_fifo
// Purpose  : Synchronous FIFO with occupancy output and a flush that wins
//            over push/pop in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign do_push = push && !flush && (level != LW'(DEPTH));
  assign do_pop  = pop  && !flush && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/actuator_update_sequencer.sv
// ============================================================================
// Module   : actuator_update_sequencer
// Purpose  : Queues cell patterns and drives each to the scanner for a
//            programmed number of full scans, with abort and async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module actuator_update_sequencer
  import actuator_update_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int REPW  = DEFAULT_REPW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pat_valid,
  input  logic [CELLS-1:0]         pat_data,
  input  logic [REPW-1:0]          pat_repeat,
  output logic                     pat_ready,
  input  logic                     abort,
  input  logic                     update_done,
  output logic [CELLS-1:0]         cells_state,
  output logic                     system_enable_n,
  output logic                     busy,
  output logic                     pattern_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int LVLW = $clog2(DEPTH) + 1;
  localparam int ENTW = CELLS + REPW;

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CELLS-1:0] cells_next;
  logic             enable_n_next;
  logic             done_next;
  logic [REPW-1:0]  rem;
  logic [REPW-1:0]  rem_next;
  logic             ud_prev;
  logic             ud_rise;
  logic             push;
  logic             pop;
  logic [ENTW-1:0]  head;
  logic [CELLS-1:0] head_pattern;
  logic [REPW-1:0]  head_repeat;

  assign pat_ready    = (fifo_level != LVLW'(DEPTH));
  assign push         = pat_valid && pat_ready && !abort;
  assign busy         = (state != S_IDLE);
  assign ud_rise      = update_done && !ud_prev;
  assign head_pattern = head[ENTW-1:REPW];
  assign head_repeat  = head[REPW-1:0];

  pattern_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (abort),
    .push      (push),
    .push_data ({pat_data, pat_repeat}),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level)
  );

  always_comb begin
    state_next    = state;
    cells_next    = cells_state;
    enable_n_next = system_enable_n;
    done_next     = 1'b0;
    rem_next      = rem;
    pop           = 1'b0;
    if (abort) begin
      state_next    = S_IDLE;
      cells_next    = '0;
      enable_n_next = 1'b1;
      rem_next      = '0;
    end else begin
      case (state)
        S_IDLE: begin
          enable_n_next = 1'b1;
          if (fifo_level != '0) begin
            pop        = 1'b1;
            cells_next = head_pattern;
            // A repeat count of zero is applied as a single scan.
            rem_next   = (head_repeat == '0) ? REPW'(1) : head_repeat;
            state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          state_next    = S_RUN;
          enable_n_next = 1'b0;
        end
        S_RUN: begin
          if (ud_rise && (rem != '0)) begin
            rem_next = rem - REPW'(1);
            if (rem == REPW'(1)) begin
              state_next    = S_DONE;
              enable_n_next = 1'b1;
              done_next     = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_next    = S_IDLE;
          enable_n_next = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cells_state     <= '0;
      system_enable_n <= 1'b1;
      pattern_done    <= 1'b0;
      rem             <= '0;
      ud_prev         <= 1'b0;
    end else begin
      state           <= state_next;
      cells_state     <= cells_next;
      system_enable_n <= enable_n_next;
      pattern_done    <= done_next;
      rem             <= rem_next;
      ud_prev         <= update_done;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_actuator_update_sequencer.sv
// ============================================================================
// Module   : tb_actuator_update_sequencer
// Purpose  : Directed self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_actuator_update_sequencer;

  localparam int DEPTH = 4;
  localparam int REPW  = 8;

  localparam int PH_WAIT   = 0;
  localparam int PH_STAGE  = 1;
  localparam int PH_SCAN   = 2;
  localparam int PH_FINISH = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            pat_valid;
  logic [9:0]      pat_data;
  logic [REPW-1:0] pat_repeat;
  logic            pat_ready;
  logic            abort;
  logic            update_done;
  logic [9:0]      cells_state;
  logic            system_enable_n;
  logic            busy;
  logic            pattern_done;
  logic [2:0]      fifo_level;

  int vectors     = 0;
  int miscompares = 0;
  int pd_count    = 0;
  logic [9:0] done_log [$];

  actuator_update_sequencer #(
    .DEPTH (DEPTH),
    .REPW  (REPW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pat_valid       (pat_valid),
    .pat_data        (pat_data),
    .pat_repeat      (pat_repeat),
    .pat_ready       (pat_ready),
    .abort           (abort),
    .update_done     (update_done),
    .cells_state     (cells_state),
    .system_enable_n (system_enable_n),
    .busy            (busy),
    .pattern_done    (pattern_done),
    .fifo_level      (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending patterns plus the phase of the
  // pattern currently applied.
  logic [9:0] mq_data [$];
  logic [7:0] mq_rep  [$];
  int         m_phase = PH_WAIT;
  logic [9:0] m_cells = '0;
  logic       m_en_n  = 1'b1;
  logic       m_done  = 1'b0;
  int         m_rem   = 0;
  logic       m_prev  = 1'b0;
  bit         m_can_push;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq_data.delete(); mq_rep.delete();
      m_phase = PH_WAIT; m_cells = '0; m_en_n = 1'b1; m_done = 1'b0;
      m_rem = 0; m_prev = 1'b0;
    end else begin
      m_can_push = pat_valid && (mq_data.size() < DEPTH);
      if (abort) begin
        mq_data.delete(); mq_rep.delete();
        m_phase = PH_WAIT; m_cells = '0; m_en_n = 1'b1; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        case (m_phase)
          PH_WAIT: if (mq_data.size() > 0) begin
            m_cells = mq_data.pop_front();
            m_rem   = (mq_rep[0] == 0) ? 1 : int'(mq_rep[0]);
            void'(mq_rep.pop_front());
            m_phase = PH_STAGE;
          end
          PH_STAGE: begin m_phase = PH_SCAN; m_en_n = 1'b0; end
          PH_SCAN: if (update_done && !m_prev && m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin m_phase = PH_FINISH; m_en_n = 1'b1; m_done = 1'b1; end
          end
          default: m_phase = PH_WAIT;
        endcase
        if (m_can_push) begin mq_data.push_back(pat_data); mq_rep.push_back(pat_repeat); end
      end
      m_prev = update_done;
    end
  end

  always @(posedge clock) begin
    #1;
    check("cells_state",     32'(cells_state),     32'(m_cells));
    check("system_enable_n", 32'(system_enable_n), 32'(m_en_n));
    check("busy",            32'(busy),            32'(m_phase != PH_WAIT));
    check("pattern_done",    32'(pattern_done),    32'(m_done));
    check("fifo_level",      32'(fifo_level),      32'(mq_data.size()));
    check("pat_ready",       32'(pat_ready),       32'(mq_data.size() != DEPTH));
    if (pattern_done) begin
      pd_count++;
      done_log.push_back(cells_state);
    end
  end

  task automatic push_wait(input logic [9:0] d, input logic [7:0] r);
    pat_valid = 1'b1; pat_data = d; pat_repeat = r;
    for (int i = 0; i < 80; i++) begin
      if (pat_ready) begin
        @(negedge clock);
        pat_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    pat_valid = 1'b0;
    check("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_run();
    for (int i = 0; i < 80; i++) begin
      if (!system_enable_n) return;
      @(negedge clock);
    end
    check("run_timeout", 32'(0), 32'(1));
  endtask

  task automatic scan(input int hold);
    wait_run();
    update_done = 1'b1;
    repeat (hold) @(negedge clock);
    update_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  int base;
  logic [9:0] order [6];

  initial begin
    reset = 1'b1; pat_valid = 1'b0; pat_data = '0; pat_repeat = '0;
    abort = 1'b0; update_done = 1'b0;
    repeat (3) @(negedge clock);
    @(posedge clock); #1;
    check("rst_cells", 32'(cells_state), 32'h0);
    check("rst_en_n",  32'(system_enable_n), 32'h1);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_ready", 32'(pat_ready), 32'h1);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    // Basic latency: push at edge N, pattern at N+1, enable at N+2.
    pat_valid = 1'b1; pat_data = 10'h2A5; pat_repeat = 8'd1;
    @(posedge clock); #1;
    check("t1_level_n", 32'(fifo_level), 32'h1);
    @(negedge clock); pat_valid = 1'b0;
    @(posedge clock); #1;
    check("t1_cells_n1", 32'(cells_state), 32'h2A5);
    check("t1_en_n_n1",  32'(system_enable_n), 32'h1);
    check("t1_busy_n1",  32'(busy), 32'h1);
    @(posedge clock); #1;
    check("t1_en_n_n2",  32'(system_enable_n), 32'h0);
    @(negedge clock); update_done = 1'b1;
    @(posedge clock); #1;
    check("t1_done",     32'(pattern_done), 32'h1);
    check("t1_en_n_done", 32'(system_enable_n), 32'h1);
    @(negedge clock); update_done = 1'b0;
    @(posedge clock); #1;
    check("t1_done_clr", 32'(pattern_done), 32'h0);
    check("t1_idle",     32'(busy), 32'h0);
    @(negedge clock);

    // Repeat 3 with update_done held high for several cycles per scan.
    base = pd_count;
    push_wait(10'h155, 8'd3);
    scan(5); scan(5);
    check("t2_no_early_done", 32'(pd_count), 32'(base));
    scan(5);
    check("t2_done_count", 32'(pd_count), 32'(base + 1));
    check("t2_done_pat",   32'(done_log[$]), 32'h155);

    // Fill the FIFO while busy; the fifth pending push waits for a pop.
    order = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020};
    base = done_log.size();
    push_wait(order[0], 8'd1);
    wait_run();
    for (int i = 1; i < 5; i++) push_wait(order[i], 8'd1);
    check("t3_full_level", 32'(fifo_level), 32'h4);
    check("t3_full_ready", 32'(pat_ready), 32'h0);
    fork
      push_wait(order[5], 8'd1);
      begin
        repeat (3) @(negedge clock);
        check("t3_blocked_level", 32'(fifo_level), 32'h4);
        scan(1);
      end
    join
    repeat (5) scan(1);
    for (int i = 0; i < 6; i++)
      check("t3_order", 32'(done_log[base + i]), 32'(order[i]));
    check("t3_drained", 32'(fifo_level), 32'h0);

    // Repeat 0 behaves as a single scan.
    base = pd_count;
    push_wait(10'h0F0, 8'd0);
    scan(1);
    check("t4_rep0_done", 32'(pd_count), 32'(base + 1));

    // Abort mid-run with two queued and a same-cycle push and scan edge.
    base = pd_count;
    push_wait(10'h3C3, 8'd2);
    wait_run();
    push_wait(10'h0AA, 8'd1);
    push_wait(10'h155, 8'd1);
    check("t5_queued", 32'(fifo_level), 32'h2);
    abort = 1'b1; pat_valid = 1'b1; pat_data = 10'h3FF; pat_repeat = 8'd1;
    update_done = 1'b1;
    @(posedge clock); #1;
    check("t5_level",  32'(fifo_level), 32'h0);
    check("t5_en_n",   32'(system_enable_n), 32'h1);
    check("t5_cells",  32'(cells_state), 32'h0);
    check("t5_done",   32'(pattern_done), 32'h0);
    @(negedge clock); abort = 1'b0; pat_valid = 1'b0; update_done = 1'b0;
    repeat (4) @(negedge clock);
    check("t5_idle",    32'(busy), 32'h0);
    check("t5_no_done", 32'(pd_count), 32'(base));

    // Asynchronous reset mid-run discards the queue immediately.
    push_wait(10'h2DB, 8'd2);
    wait_run();
    push_wait(10'h124, 8'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_cells", 32'(cells_state), 32'h0);
    check("t6_en_n",  32'(system_enable_n), 32'h1);
    check("t6_busy",  32'(busy), 32'h0);
    check("t6_done",  32'(pattern_done), 32'h0);
    check("t6_level", 32'(fifo_level), 32'h0);
    check("t6_ready", 32'(pat_ready), 32'h1);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_level_after", 32'(fifo_level), 32'h0);
    check("t6_busy_after",  32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/actuator_update_sequencer.md
ACTUATOR_UPDATE_SEQUENCER -- requirements
Module: actuator_update_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the pattern FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have parameter REPW, default 8, giving the repeat-count width.
REQ-003 The block SHALL run on one clock and use an asynchronous, active-high reset.
REQ-004 Port: clock  input  1  block clock.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: pat_valid  input  1  requester offers a pattern.
REQ-007 Port: pat_data  input  10  cell pattern, one bit per cell.
REQ-008 Port: pat_repeat  input  REPW  full matrix scans to apply the pattern (0 treated as 1).
REQ-009 Port: pat_ready  output  1  FIFO can accept a pattern.
REQ-010 Port: abort  input  1  flush the queue and stop driving.
REQ-011 Port: update_done  input  1  scan-complete level from the cell scanner.
REQ-012 Port: cells_state  output  10  pattern presented to the scanner.
REQ-013 Port: system_enable_n  output  1  scanner enable, active low.
REQ-014 Port: busy  output  1  a pattern is loaded or being applied.
REQ-015 Port: pattern_done  output  1  one-cycle pulse when a pattern's repeats are finished.
REQ-016 Port: fifo_level  output  $clog2(DEPTH)+1  entries currently queued.

Function
REQ-017 A push SHALL occur on a clock edge where pat_valid and pat_ready are both high; {pat_data, pat_repeat} is enqueued.
REQ-018 pat_ready SHALL equal (fifo_level != DEPTH); there is no bypass, so a push never becomes the head in the same cycle.
REQ-019 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-020 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-021 IDLE: system_enable_n=1, busy=0; on a non-empty FIFO, pop the head, register cells_state<=pattern and rem<=max(repeat,1), and go to LOAD.
REQ-022 LOAD: busy=1; go to RUN at the next edge, driving system_enable_n=0 from that edge.
REQ-023 RUN: cells_state SHALL be held stable.
REQ-024 RUN: each rising edge of update_done (registered previous value 0, current 1) SHALL decrement rem.
REQ-025 RUN: when the decrement takes rem from 1 to 0, go to DONE with system_enable_n=1.
REQ-026 DONE: lasts exactly one cycle with pattern_done=1 and system_enable_n=1, resetting the scanner position; then go to IDLE.
REQ-027 Back-to-back patterns SHALL therefore have at least 2 cycles with system_enable_n=1 between them (DONE plus IDLE).
REQ-028 End-to-end latency: a push into an empty FIFO while in IDLE at edge N SHALL give cells_state valid after edge N+1 and system_enable_n low after edge N+2.
REQ-029 A held-high update_done SHALL count once; update_done SHALL be ignored outside RUN.
REQ-030 abort SHALL take priority over every event in the same cycle.
REQ-031 On abort the block SHALL empty the FIFO (level 0), drop any same-cycle push, go to IDLE, and drive system_enable_n=1, cells_state=0 and pattern_done=0 at the next edge.
REQ-032 rem SHALL be REPW bits; it never wraps because it is only decremented while nonzero.

Reset
REQ-033 While reset is asserted, outputs SHALL be: cells_state=0, system_enable_n=1, busy=0, pattern_done=0, fifo_level=0, pat_ready=1.
REQ-034 While reset is asserted, the FSM SHALL be in IDLE and the update_done edge register SHALL be 0.
REQ-035 Reset asserted mid-RUN SHALL take effect immediately (asynchronously) and discard queued patterns.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, CELLS=10 and the default DEPTH/REPW constants.
REQ-037 The FIFO SHALL be a separate sub-module, pattern_fifo, a synchronous FIFO with level output and flush input.

Verification
REQ-038 Reset, then push pat 10'h2A5 with repeat 1 -> cells_state=10'h2A5 at N+1, system_enable_n=0 at N+2; one update_done pulse -> pattern_done pulse, then IDLE.
REQ-039 Repeat 3 with update_done held high 5 cycles per scan -> exactly 3 counted, pattern_done after the third rising edge.
REQ-040 Push 5 patterns with DEPTH=4 while busy -> pat_ready low at level 4; the fifth is accepted only after a pop; patterns are applied in order.
REQ-041 Repeat 0 -> behaves as repeat 1.
REQ-042 abort mid-RUN with 2 queued plus a same-cycle push -> level 0, system_enable_n=1, cells_state=0 next edge, no pattern_done.
REQ-043 Reset asserted mid-RUN -> all outputs at reset values immediately, without waiting for a clock edge.
